sync_gen: RTL and testbench

SYNC_GEN -- requirements
Module: sync_gen

---
 rtl/dvi_timing_pkg.sv | 30 +++
 rtl/sync_axis.sv | 71 +++++++
 rtl/sync_gen.sv | 121 ++++++++++++
 tb/tb_sync_gen.sv | 126 ++++++++++++
 4 files changed

// File: rtl/dvi_timing_pkg.sv
// Shared display-timing definitions: XGA 60 Hz defaults and the region
// encoding used by the sync generator and by downstream pixel renderers.
package dvi_timing;

    localparam int CNT_W = 11;

    localparam int XGA_H_ACT = 1024;
    localparam int XGA_H_FP  = 24;
    localparam int XGA_H_SW  = 136;
    localparam int XGA_H_BP  = 160;
    localparam int XGA_V_ACT = 768;
    localparam int XGA_V_FP  = 3;
    localparam int XGA_V_SW  = 6;
    localparam int XGA_V_BP  = 29;

    localparam bit XGA_HS_POL = 1'b0;
    localparam bit XGA_VS_POL = 1'b0;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } region_e;

    function automatic int axis_period(input int act, input int fp, input int sw, input int bp);
        return act + fp + sw + bp;
    endfunction

endpackage

// File: rtl/sync_axis.sv
// One timing axis: a four-region FSM with an in-region counter that only
// steps when adv_i is high. Used for both the horizontal and vertical axes.
module sync_axis
    import dvi_timing::*;
#(
    parameter int ACT_LEN = XGA_H_ACT,
    parameter int FP_LEN  = XGA_H_FP,
    parameter int SW_LEN  = XGA_H_SW,
    parameter int BP_LEN  = XGA_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    output logic [CNT_W-1:0] count_o,
    output logic             active_o,
    output logic             sync_o,
    output logic             last_o
);

    region_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] endCnt;
    logic             atEnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        endCnt  = CNT_W'(ACT_LEN - 1);
        case (state_q)
            ST_ACTIVE: endCnt = CNT_W'(ACT_LEN - 1);
            ST_FRONT:  endCnt = CNT_W'(FP_LEN - 1);
            ST_SYNC:   endCnt = CNT_W'(SW_LEN - 1);
            ST_BACK:   endCnt = CNT_W'(BP_LEN - 1);
            default:   endCnt = CNT_W'(ACT_LEN - 1);
        endcase
        atEnd = (cnt_q == endCnt);

        // The counter restarts at every region change, so it doubles as the
        // pixel/line coordinate while in the active region.
        if (adv_i) begin
            if (atEnd) begin
                cnt_d = '0;
                case (state_q)
                    ST_ACTIVE: state_d = ST_FRONT;
                    ST_FRONT:  state_d = ST_SYNC;
                    ST_SYNC:   state_d = ST_BACK;
                    ST_BACK:   state_d = ST_ACTIVE;
                    default:   state_d = ST_ACTIVE;
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign count_o  = cnt_q;
    assign active_o = (state_q == ST_ACTIVE);
    assign sync_o   = (state_q == ST_SYNC);
    assign last_o   = (state_q == ST_BACK) && atEnd;

endmodule

// File: rtl/sync_gen.sv
// Video sync generator: horizontal and vertical timing axes with all
// outputs registered one enabled cycle behind the axis state.
module sync_gen
    import dvi_timing::*;
#(
    parameter int H_ACT  = XGA_H_ACT,
    parameter int H_FP   = XGA_H_FP,
    parameter int H_SW   = XGA_H_SW,
    parameter int H_BP   = XGA_H_BP,
    parameter int V_ACT  = XGA_V_ACT,
    parameter int V_FP   = XGA_V_FP,
    parameter int V_SW   = XGA_V_SW,
    parameter int V_BP   = XGA_V_BP,
    parameter bit HS_POL = XGA_HS_POL,
    parameter bit VS_POL = XGA_VS_POL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic             o_sync_vs,
    output logic             o_sync_hs,
    output logic             o_sync_va,
    output logic             o_sync_ha,
    output logic             o_sync_de,
    output logic [CNT_W-1:0] o_pix_x,
    output logic [CNT_W-1:0] o_pix_y,
    output logic             o_frame_start
);

    logic [CNT_W-1:0] hCount, vCount;
    logic             hActive, hSync, hLast;
    logic             vActive, vSync, vLast;
    logic             vAdv;

    // The vertical axis steps once per line, on the final back-porch cycle.
    assign vAdv = i_en & hLast;

    sync_axis #(
        .ACT_LEN (H_ACT),
        .FP_LEN  (H_FP),
        .SW_LEN  (H_SW),
        .BP_LEN  (H_BP)
    ) u_h_axis (
        .clk      (clk),
        .rst      (rst),
        .adv_i    (i_en),
        .count_o  (hCount),
        .active_o (hActive),
        .sync_o   (hSync),
        .last_o   (hLast)
    );

    sync_axis #(
        .ACT_LEN (V_ACT),
        .FP_LEN  (V_FP),
        .SW_LEN  (V_SW),
        .BP_LEN  (V_BP)
    ) u_v_axis (
        .clk      (clk),
        .rst      (rst),
        .adv_i    (vAdv),
        .count_o  (vCount),
        .active_o (vActive),
        .sync_o   (vSync),
        .last_o   (vLast)
    );

    logic             hs_d, vs_d, ha_d, va_d, de_d, fs_d;
    logic             hs_q, vs_q, ha_q, va_q, de_q, fs_q;
    logic [CNT_W-1:0] x_d, y_d, x_q, y_q;
    logic             frameEnd;

    // Frame end is decoded but only needed by renderers probing hierarchy.
    assign frameEnd = hLast & vLast;

    always_comb begin
        hs_d = hSync ? HS_POL : ~HS_POL;
        vs_d = vSync ? VS_POL : ~VS_POL;
        ha_d = hActive;
        va_d = vActive;
        de_d = hActive & vActive;
        x_d  = de_d ? hCount : '0;
        y_d  = de_d ? vCount : '0;
        fs_d = de_d && (hCount == '0) && (vCount == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            ha_q <= 1'b0;
            va_q <= 1'b0;
            de_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
            fs_q <= 1'b0;
        end else if (i_en) begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            ha_q <= ha_d;
            va_q <= va_d;
            de_q <= de_d;
            x_q  <= x_d;
            y_q  <= y_d;
            fs_q <= fs_d;
        end
    end

    assign o_sync_hs     = hs_q;
    assign o_sync_vs     = vs_q;
    assign o_sync_ha     = ha_q;
    assign o_sync_va     = va_q;
    assign o_sync_de     = de_q;
    assign o_pix_x       = x_q;
    assign o_pix_y       = y_q;
    assign o_frame_start = fs_q;

    logic unusedFrameEnd;
    assign unusedFrameEnd = frameEnd;

endmodule

// File: tb/tb_sync_gen.sv
// Bench for sync_gen using a reduced timing set; expected outputs come from
// the pixel position implied by the number of enabled cycles since reset.
module tb_sync_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_en = 1'b0;
    logic        o_sync_vs, o_sync_hs, o_sync_va, o_sync_ha, o_sync_de, o_frame_start;
    logic [10:0] o_pix_x, o_pix_y;

    int total = 0;
    int bad = 0;
    int t = 0;
    int deCount;
    int fsCount;

    sync_gen #(
        .H_ACT (HA), .H_FP (HF), .H_SW (HS), .H_BP (HB),
        .V_ACT (VA), .V_FP (VF), .V_SW (VS), .V_BP (VB),
        .HS_POL (1'b0), .VS_POL (1'b0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_en          (i_en),
        .o_sync_vs     (o_sync_vs),
        .o_sync_hs     (o_sync_hs),
        .o_sync_va     (o_sync_va),
        .o_sync_ha     (o_sync_ha),
        .o_sync_de     (o_sync_de),
        .o_pix_x       (o_pix_x),
        .o_pix_y       (o_pix_y),
        .o_frame_start (o_frame_start)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d t=%0d", tag, obs, exp, t);
        end
    endtask

    // Expected outputs for the pixel shown after t enabled cycles since reset.
    task automatic checkOutput();
        int p, col, line;
        logic eha, eva, ehs, evs, ede, efs;
        logic [10:0] ex, ey;
        if (t == 0) begin
            eha = 0; eva = 0; ehs = 1; evs = 1; ede = 0; efs = 0; ex = 0; ey = 0;
        end else begin
            p    = (t - 1) % FRAME;
            col  = p % HT;
            line = p / HT;
            eha  = (col < HA);
            eva  = (line < VA);
            ehs  = !(col >= HA + HF && col < HA + HF + HS);
            evs  = !(line >= VA + VF && line < VA + VF + VS);
            ede  = eha & eva;
            ex   = ede ? 11'(col) : 11'd0;
            ey   = ede ? 11'(line) : 11'd0;
            efs  = (p == 0);
        end
        cmp("hs", 11'(o_sync_hs), 11'(ehs));
        cmp("vs", 11'(o_sync_vs), 11'(evs));
        cmp("ha", 11'(o_sync_ha), 11'(eha));
        cmp("va", 11'(o_sync_va), 11'(eva));
        cmp("de", 11'(o_sync_de), 11'(ede));
        cmp("pix_x", o_pix_x, ex);
        cmp("pix_y", o_pix_y, ey);
        cmp("frame_start", 11'(o_frame_start), 11'(efs));
        cmp("and_gate", 11'(o_sync_vs & o_sync_hs & o_sync_va & o_sync_ha & o_sync_de), 11'(ede));
    endtask

    task automatic applyStimulus(input logic en, input logic r);
        @(negedge clk);
        i_en = en;
        rst  = r;
        @(posedge clk);
        #1;
        if (r) t = 0;
        else if (en) t++;
        checkOutput();
    endtask

    initial begin
        // Reset, including a reset cycle with enable low.
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);

        // Two full frames plus a few cycles with continuous enable.
        deCount = 0;
        fsCount = 0;
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b1, 1'b0);
            deCount += int'(o_sync_de);
            fsCount += int'(o_frame_start);
        end
        cmp("de_per_frame", 11'(deCount), 11'(HA * VA));
        cmp("fs_per_frame", 11'(fsCount), 11'd1);
        for (int i = 0; i < FRAME + 5; i++) applyStimulus(1'b1, 1'b0);

        // Randomly gated enable: the shown pixel must follow enabled cycles only.
        for (int i = 0; i < 4 * FRAME; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0);

        // Run to pixel (5,2) and reset there.
        for (int i = 0; i < FRAME && !(o_pix_x == 11'd5 && o_pix_y == 11'd2 && o_sync_de); i++)
            applyStimulus(1'b1, 1'b0);
        cmp("reached_5_2", 11'(o_pix_x == 11'd5 && o_pix_y == 11'd2 && o_sync_de), 11'd1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
